// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared combinational ALU.
// Operand register feeds the ALU; the result is captured per requester one edge later.
module alu_arbiter #(
  parameter int ARCH_BITS = 32,
  parameter int OPC_BITS  = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [OPC_BITS-1:0]  req0_opcode,
  input  logic [ARCH_BITS-1:0] req0_data1,
  input  logic [ARCH_BITS-1:0] req0_data2,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [OPC_BITS-1:0]  req1_opcode,
  input  logic [ARCH_BITS-1:0] req1_data1,
  input  logic [ARCH_BITS-1:0] req1_data2,
  output logic                 req1_ready,
  input  logic                 stall,
  output logic [OPC_BITS-1:0]  alu_opcode,
  output logic [ARCH_BITS-1:0] alu_data1,
  output logic [ARCH_BITS-1:0] alu_data2,
  input  logic [ARCH_BITS-1:0] alu_res,
  output logic                 rsp0_valid,
  output logic [ARCH_BITS-1:0] rsp0_res,
  output logic                 rsp1_valid,
  output logic [ARCH_BITS-1:0] rsp1_res,
  output logic                 busy
);

  localparam int NUM_REQ = 2;

  logic                               rr_last;   // 1: requester 1 was granted last
  logic                               iss_valid;
  logic                               iss_tag;
  logic                               xfer0, xfer1;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [NUM_REQ-1:0][ARCH_BITS-1:0]  rsp_res;

  // Grant the requester that did not win last when both contend.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!stall) begin
      req0_ready = req0_valid & (!req1_valid | rr_last);
      req1_ready = req1_valid & (!req0_valid | !rr_last);
    end
  end

  assign xfer0 = req0_valid & req0_ready;
  assign xfer1 = req1_valid & req1_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last    <= 1'b1;
      iss_valid  <= 1'b0;
      iss_tag    <= 1'b0;
      alu_opcode <= '0;
      alu_data1  <= '0;
      alu_data2  <= '0;
    end else if (xfer0) begin
      rr_last    <= 1'b0;
      iss_valid  <= 1'b1;
      iss_tag    <= 1'b0;
      alu_opcode <= req0_opcode;
      alu_data1  <= req0_data1;
      alu_data2  <= req0_data2;
    end else if (xfer1) begin
      rr_last    <= 1'b1;
      iss_valid  <= 1'b1;
      iss_tag    <= 1'b1;
      alu_opcode <= req1_opcode;
      alu_data1  <= req1_data1;
      alu_data2  <= req1_data2;
    end else begin
      iss_valid  <= 1'b0;
    end
  end

  // Result data only moves when its pulse fires, so the last result stays readable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_res   <= '0;
    end else begin
      for (int t = 0; t < NUM_REQ; t++) begin
        rsp_valid[t] <= iss_valid & (iss_tag == t[0]);
        if (iss_valid & (iss_tag == t[0]))
          rsp_res[t] <= alu_res;
      end
    end
  end

  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_res   = rsp_res[0];
  assign rsp1_res   = rsp_res[1];
  assign busy       = iss_valid;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the processor's single combinational ALU between two requesters:
  - requester 0: main execute stage.
  - requester 1: address-generation / auxiliary unit.
- Behaviour: round-robin arbitration, a registered operand stage and a registered per-requester result stage.
- Position: sits between the requesters and the ALU. It drives the ALU opcode and operands and captures the ALU result.

Parameters:
- ARCH_BITS, 32, datapath width; must match proc.ARCH_BITS.
- OPC_BITS, 7, opcode width; must match the ALU opcode port.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_opcode  in  OPC_BITS  requester 0 opcode.
- req0_data1  in  ARCH_BITS  requester 0 operand 1.
- req0_data2  in  ARCH_BITS  requester 0 operand 2.
- req0_ready  out  1  requester 0 transfer accepted this cycle.
- req1_valid, req1_opcode, req1_data1, req1_data2, req1_ready  same as requester 0, for requester 1.
- stall  in  1  freezes acceptance of new requests.
- alu_opcode  out  OPC_BITS  to ALU opcode.
- alu_data1  out  ARCH_BITS  to ALU data1.
- alu_data2  out  ARCH_BITS  to ALU data2.
- alu_res  in  ARCH_BITS  ALU result (combinational from alu_* outputs).
- rsp0_valid  out  1  one-cycle pulse: result for requester 0.
- rsp0_res  out  ARCH_BITS  requester 0 result.
- rsp1_valid  out  1  one-cycle pulse: result for requester 1.
- rsp1_res  out  ARCH_BITS  requester 1 result.
- busy  out  1  operand stage holds a valid operation.

Behaviour:
- Reset (rst low, asynchronous, any cycle):
  - Clears the operand stage: iss_valid=0, iss_tag=0, alu_opcode=0, alu_data1=0, alu_data2=0.
  - Clears all rsp*_valid and rsp*_res to 0; busy=0.
  - Sets rr pointer to "requester 1 granted last", so requester 0 wins first.
  - In-flight operations are discarded, with no response pulse after reset release.
- Arbitration is combinational on current inputs:
  - stall=1 -> req0_ready=req1_ready=0.
  - Else only one valid -> that requester is ready.
  - Both valid -> the requester not granted last is ready.
  - At most one ready is high in any cycle.
- Transfer: reqN_valid & reqN_ready at a rising edge.
  - Loads opcode/data1/data2 into the operand stage and sets iss_valid=1, iss_tag=N.
  - Updates rr pointer to N.
  - rr pointer changes only on a transfer.
- No transfer at an edge: iss_valid<=0. alu_* registers hold their last values; they are don't-care when iss_valid=0.
- Result stage, at each edge:
  - rspT_valid <= iss_valid & (iss_tag==T).
  - rspT_res <= alu_res only when that rspT_valid loads 1; otherwise rspT_res holds.
- Latency: a request accepted at edge E0 produces rspN_valid high for exactly the cycle following edge E1 (two edges total).
- Throughput: one operation per cycle. Back-to-back transfers are pipelined with no bubble.
- No response backpressure. Requesters must sample the pulse.
- stall affects only acceptance. An operation already in the operand stage still completes and pulses its response.
- busy = iss_valid.
- Arithmetic: none performed here. Results are passed through exactly, including wrap-around and the ALU's all-ones value for unsupported opcodes.
- Requester holding valid while not ready: its inputs must stay stable. The arbiter does not latch them before grant.
- Simultaneous request and stall release: arbitration uses the stall value of the current cycle only.

Test Plan:
- Single request: after reset, req0 ADD data1=5, data2=3, held one cycle -> req0_ready=1 same cycle; rsp0_valid one-cycle pulse two edges later with rsp0_res=8; rsp1_valid stays 0.
- Contention: both requesters valid continuously for 4 cycles (req0 SUB 10-4, req1 ADD 1+1) -> grants alternate 0,1,0,1; responses alternate 6,2,6,2 with no bubbles; busy=1 throughout.
- Wrap/unknown opcode: req1 ADD 32'hFFFFFFFF+1 -> rsp1_res=0. Then req1 with an unsupported opcode -> rsp1_res=32'hFFFFFFFF.
- Stall: stall=1 the cycle after accepting req0 ADD 2+2, req1 valid -> rsp0 still pulses 4; req1_ready stays 0 until stall=0, then req1 is granted.
- Reset mid-operation: accept req0, assert rst low before the response edge -> no rsp0_valid pulse; all outputs 0; first grant after release goes to req0 when both are valid.
- Fairness pointer: only req1 valid for 3 transfers, then both valid -> req0 is granted first.
